// File: rtl/regfile_if.sv
// regfile_if: operand read, writeback and flag/branch signals between datapath control and regfile_flags
interface regfile_if #(parameter int WIDTH = 4, parameter int AW = 4);
  logic [AW-1:0] ra1, ra2, wa3;
  logic [WIDTH-1:0] rd1, rd2, wd3;
  logic we3, flag_we, zero_in, carry_in, sign_in;
  logic zero, carry, sign, take;
  logic [1:0] cond;
  modport master (
    output ra1, ra2, we3, wa3, wd3, flag_we, zero_in, carry_in, sign_in, cond,
    input  rd1, rd2, zero, carry, sign, take
  );
  modport slave (
    input  ra1, ra2, we3, wa3, wd3, flag_we, zero_in, carry_in, sign_in, cond,
    output rd1, rd2, zero, carry, sign, take
  );
endinterface

// File: rtl/regfile_flags.sv
// regfile_flags: 2**AW x WIDTH register bank (r0 hard-wired to 0) plus ALU flag register and branch condition
module regfile_flags #(
  parameter int WIDTH = 4,
  parameter int AW    = 4
) (
  input logic     clk,
  input logic     reset,
  regfile_if.slave bus
);
  localparam int N = 2 ** AW;
  logic [WIDTH-1:0] regs [N];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < N; i++) regs[i] <= '0;
    else if (bus.we3 && bus.wa3 != '0)
      regs[bus.wa3] <= bus.wd3;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      {bus.zero, bus.carry, bus.sign} <= 3'b000;
    else if (bus.flag_we)
      {bus.zero, bus.carry, bus.sign} <= {bus.zero_in, bus.carry_in, bus.sign_in};
  // no write bypass: keeps the ALU-to-writeback loop free of combinational cycles
  always_comb begin
    bus.rd1  = regs[bus.ra1];
    bus.rd2  = regs[bus.ra2];
    bus.take = bus.cond == 2'd0 ? 1'b1 :
               bus.cond == 2'd1 ? bus.zero :
               bus.cond == 2'd2 ? bus.carry : bus.sign;
  end
endmodule

// File: tb/tb_regfile_flags.sv
// tb_regfile_flags: scoreboard bench for regfile_flags against an array-based reference model
module tb_regfile_flags;
  logic clk = 1'b0;
  logic reset = 1'b1;
  regfile_if #(.WIDTH(4), .AW(4)) bus();
  regfile_flags #(.WIDTH(4), .AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rd1, rd2;
    logic z, c, s, t;
    string name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] mdl [16];
  logic mz, mc, ms;
  logic [4:0] sum;

  function automatic void push_exp(string name);
    exp_t e;
    logic [3:0] tv;
    tv = {ms, mc, mz, 1'b1};
    e.rd1 = mdl[bus.ra1];
    e.rd2 = mdl[bus.ra2];
    e.z = mz;
    e.c = mc;
    e.s = ms;
    e.t = tv[bus.cond];
    e.name = name;
    q.push_back(e);
  endfunction

  task automatic assert_reset();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = 4'h0;
    {mz, mc, ms} = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (bus.we3 && bus.wa3 != 4'd0) mdl[bus.wa3] = bus.wd3;
      if (bus.flag_we) {mz, mc, ms} = {bus.zero_in, bus.carry_in, bus.sign_in};
    end
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [3:0] d);
    bus.we3 = 1'b1;
    bus.wa3 = a;
    bus.wd3 = d;
    tick();
    bus.we3 = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bus.we3 = 1'($urandom);
      bus.wa3 = 4'($urandom);
      bus.wd3 = 4'($urandom);
      bus.flag_we = 1'($urandom);
      {bus.zero_in, bus.carry_in, bus.sign_in} = 3'($urandom);
      bus.ra1 = 4'($urandom);
      bus.ra2 = ($urandom_range(3) == 0) ? bus.ra1 : 4'($urandom);
      bus.cond = 2'($urandom);
      push_exp("random");
      tick();
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.rd1, bus.rd2, bus.zero, bus.carry, bus.sign, bus.take} !==
            {e.rd1, e.rd2, e.z, e.c, e.s, e.t}) begin
          errors++;
          $display("FAIL %s @%0t: got rd1=%h rd2=%h zcs=%b%b%b take=%b, want rd1=%h rd2=%h zcs=%b%b%b take=%b",
                   e.name, $time, bus.rd1, bus.rd2, bus.zero, bus.carry, bus.sign, bus.take,
                   e.rd1, e.rd2, e.z, e.c, e.s, e.t);
        end
      end
    end
  end

  initial begin
    {bus.ra1, bus.ra2, bus.wa3, bus.wd3} = '0;
    {bus.we3, bus.flag_we, bus.zero_in, bus.carry_in, bus.sign_in} = '0;
    bus.cond = 2'd0;
    assert_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.ra1 = 4'(i);
      bus.ra2 = 4'(15 - i);
      bus.cond = 2'(i);
      push_exp("reset_init");
      tick();
    end
    reset = 1'b0;
    random_cycles(150);
    bus.we3 = 1'b0;
    bus.flag_we = 1'b0;
    assert_reset();
    for (int i = 0; i < 16; i++) begin
      bus.ra1 = 4'(i);
      bus.ra2 = 4'(15 - i);
      bus.cond = (i % 2 == 1) ? 2'd1 : 2'd0;
      push_exp("async_reset_sweep");
      tick();
    end
    reset = 1'b0;
    bus.we3 = 1'b1;
    bus.wa3 = 4'd5;
    bus.wd3 = 4'hA;
    bus.ra1 = 4'd5;
    bus.ra2 = 4'd5;
    bus.cond = 2'd0;
    push_exp("write_no_bypass");
    tick();
    bus.we3 = 1'b0;
    push_exp("write_readback");
    tick();
    write_reg(4'd0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      bus.ra1 = 4'(i);
      bus.ra2 = 4'(i);
      push_exp("r0_protect_sweep");
      tick();
    end
    bus.flag_we = 1'b1;
    {bus.zero_in, bus.carry_in, bus.sign_in} = 3'b101;
    tick();
    bus.flag_we = 1'b0;
    {bus.zero_in, bus.carry_in, bus.sign_in} = 3'b010;
    tick();
    bus.cond = 2'd3;
    push_exp("flag_hold_sign");
    tick();
    bus.cond = 2'd2;
    push_exp("flag_hold_carry");
    tick();
    write_reg(4'd1, 4'h7);
    write_reg(4'd2, 4'h9);
    bus.ra1 = 4'd1;
    bus.ra2 = 4'd2;
    #1;
    sum = {1'b0, bus.rd1} + {1'b0, bus.rd2};
    bus.we3 = 1'b1;
    bus.wa3 = 4'd3;
    bus.wd3 = sum[3:0];
    bus.flag_we = 1'b1;
    {bus.zero_in, bus.carry_in, bus.sign_in} = {sum[3:0] == 4'h0, sum[4], sum[3]};
    push_exp("alu_operands");
    tick();
    bus.we3 = 1'b0;
    bus.flag_we = 1'b0;
    bus.ra1 = 4'd3;
    bus.cond = 2'd1;
    push_exp("alu_result");
    tick();
    bus.we3 = 1'b1;
    bus.wa3 = 4'd7;
    bus.wd3 = 4'h5;
    bus.ra1 = 4'd7;
    bus.ra2 = 4'd3;
    @(negedge clk);
    #4;
    assert_reset();
    tick();
    reset = 1'b0;
    bus.we3 = 1'b0;
    push_exp("reset_beats_write");
    tick();
    write_reg(4'd7, 4'hC);
    push_exp("write_after_reset");
    tick();
    random_cycles(100);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
